iso16_vector_sequencer: RTL and testbench
=========================================

# iso16_vector_sequencer

Hardware initiator for the ISO‑16 True Delivery Loop. It accepts queued (vector_id, epsilon) commands and issues one `start` pulse per command to `iso16_true_delivery`. It then waits for `seal_ready`, or times out, and returns the captured seal and verdict on a response handshake. It replaces bench-driven stimulus so that runs can be sequenced autonomously in silicon.

## Interface
- CMD_DEPTH, 4: command FIFO depth; power of two, ≥2.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT before a timeout response; ≥2.
- GAP_CYCLES, 2: idle cycles after each response before the next launch; 0 allowed.
- CW: derived, $clog2(CMD_DEPTH+1).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_vector_id  in  16  vector ID for the command.
- cmd_epsilon  in  32  error threshold for the command.
- start  out  1  one-cycle launch pulse to the delivery loop.
- vector_id  out  16  ID of the current run.
- epsilon  out  32  threshold of the current run.
- seal_ready  in  1  seal valid (level) from the delivery loop.
- true_delivery  in  1  verdict from the delivery loop.
- seal  in  256  seal from the delivery loop.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_vector_id  out  16  ID of the completed run.
- rsp_seal  out  256  captured seal; 0 on timeout.
- rsp_true_delivery  out  1  captured verdict; 0 on timeout.
- rsp_timeout  out  1  run ended by timeout.
- busy  out  1  state ≠ IDLE.
- cmd_count  out  CW  FIFO occupancy.

## Operation
- Command FIFO: push when cmd_valid && cmd_ready, with cmd_ready = (cmd_count != CMD_DEPTH).
  - No fall-through: a pop uses only entries present at the start of the cycle.
  - A push and a pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, LAUNCH, WAIT, RESP, GAP.
  - IDLE: if cmd_count != 0, pop the head, register it into vector_id/epsilon, then go to LAUNCH. Otherwise stay.
  - LAUNCH: start = 1 for exactly this cycle. Clear the timer and the `armed` flag, then go to WAIT.
  - WAIT:
    - Increment the timer each cycle.
    - Set `armed` when seal_ready is sampled low. A seal_ready held high from the previous run is therefore never mistaken for completion.
    - Completion: armed && seal_ready. Capture seal and true_delivery, set rsp_timeout = 0, and go to RESP.
    - Timeout: no completion, and this is the TIMEOUT_CYCLES-th WAIT cycle. Set rsp_seal = 0, rsp_true_delivery = 0, rsp_timeout = 1, and go to RESP.
    - If completion and timeout fall on the same cycle, completion wins.
  - RESP: rsp_valid = 1. All rsp_* outputs stay stable until rsp_ready. On accept, go to GAP, or to IDLE if GAP_CYCLES = 0.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- vector_id and epsilon hold their values from the IDLE pop until the next pop. rsp_vector_id equals vector_id when captured.
- Commands keep being accepted in any state while the FIFO is not full.

## Timing
- All outputs are registered.
- Reset values: start 0, vector_id 0, epsilon 0, rsp_valid 0, rsp_vector_id 0, rsp_seal 0, rsp_true_delivery 0, rsp_timeout 0, busy 0, cmd_count 0, cmd_ready 1. The state resets to IDLE.
- Command accepted at cycle C with the FIFO empty and state IDLE: pop at C+1, start = 1 at C+2.
- Completion detected in WAIT cycle K: rsp_valid = 1 from K+1.
- No completion, start at S: the WAIT cycles are S+1 … S+TIMEOUT_CYCLES, and rsp_valid = 1 with rsp_timeout at S+TIMEOUT_CYCLES+1.
- Response accepted at R: next start at R+GAP_CYCLES+2, if a command is queued.
- Reset asserted mid-run, in any state:
  - takes effect on the next edge;
  - abandons the run and flushes the FIFO;
  - no response is emitted;
  - seal_ready arriving later is ignored until a new LAUNCH.
- Each start pulse is exactly one cycle wide. There is never more than one outstanding run.

## Test plan
- Single run: cmd 0x0001 / eps 10. The model raises seal_ready 8 cycles after start with seal = {8{32'hA5A5_0001}} and true_delivery = 1. Required: start at C+2; rsp_valid at start+9 with ID 0x0001, seal matching, true_delivery 1, timeout 0.
- Stale seal_ready: two commands (0x0001, 0x0002). The model holds seal_ready high until 3 cycles after the second start, then raises it again 5 cycles later. Required: the second response comes only after the re-raise; response IDs are in order 0x0001, 0x0002.
- Timeout: TIMEOUT_CYCLES = 16, seal_ready tied low, start at S. Required: rsp_valid at S+17 with rsp_timeout 1, rsp_seal 0, rsp_true_delivery 0.
- Backpressure/full: CMD_DEPTH = 4, rsp_ready = 0, cmd_valid held high with 6 distinct IDs. Required: exactly 5 commands accepted (1 launched + 4 queued); cmd_ready 0 and cmd_count 4 thereafter; rsp_* stable while rsp_ready is low.
- Gap spacing: GAP_CYCLES = 2, two commands queued, first response accepted at R. Required: second start at exactly R+4.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT with 2 commands queued. Required: on the next cycle all outputs are at reset values and cmd_count is 0; no rsp_valid and no start afterwards without new commands.

Source files
------------

// File: rtl/iso16_vector_sequencer.sv
// Command-queued initiator for the ISO-16 True Delivery Loop: launches one run per queued
// (vector_id, epsilon), waits for a freshly raised seal or a timeout, and returns the result.
module iso16_vector_sequencer #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned GAP_CYCLES     = 2,
    localparam int unsigned CW            = $clog2(CMD_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [15:0]   cmd_vector_id,
    input  logic [31:0]   cmd_epsilon,
    output logic          start,
    output logic [15:0]   vector_id,
    output logic [31:0]   epsilon,
    input  logic          seal_ready,
    input  logic          true_delivery,
    input  logic [255:0]  seal,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [15:0]   rsp_vector_id,
    output logic [255:0]  rsp_seal,
    output logic          rsp_true_delivery,
    output logic          rsp_timeout,
    output logic          busy,
    output logic [CW-1:0] cmd_count
);

    localparam int unsigned IDW   = 16;
    localparam int unsigned EPSW  = 32;
    localparam int unsigned SEALW = 256;
    localparam int unsigned PW    = $clog2(CMD_DEPTH);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef struct packed {
        logic [IDW-1:0]  vector_id;
        logic [EPSW-1:0] epsilon;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP,
        GAP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic            armed_q;
    logic            armed_d;
    logic [GW-1:0]   gap_q;
    logic [GW-1:0]   gap_d;
    logic            pop;
    logic            push;
    logic            cap_done;
    logic            cap_timeout;

    cmd_t            fifo_mem [CMD_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_d;
    cmd_t            head;

    assign push = cmd_valid && cmd_ready;
    assign head = fifo_mem[rd_ptr];

    // FIFO occupancy after this cycle's push/pop; simultaneous push and pop cancel
    always_comb begin
        count_d = cmd_count;
        if (push && !pop) begin
            count_d = cmd_count + CW'(1);
        end else if (!push && pop) begin
            count_d = cmd_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cmd_count <= count_d;
            cmd_ready <= (count_d != CW'(CMD_DEPTH));
        end
    end

    // Storage is not reset; occupancy and pointers alone define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_vector_id, cmd_epsilon};
        end
    end

    // Next-state logic; armed guards against a seal_ready level left over from the previous run
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        armed_d     = armed_q;
        gap_d       = gap_q;
        pop         = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_count != '0) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                armed_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                armed_d = armed_q | ~seal_ready;
                if (armed_q && seal_ready) begin
                    cap_done = 1'b1;
                    state_d  = RESP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    cap_timeout = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            timer_q           <= '0;
            armed_q           <= 1'b0;
            gap_q             <= '0;
            start             <= 1'b0;
            busy              <= 1'b0;
            rsp_valid         <= 1'b0;
            vector_id         <= '0;
            epsilon           <= '0;
            rsp_vector_id     <= '0;
            rsp_seal          <= '0;
            rsp_true_delivery <= 1'b0;
            rsp_timeout       <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            armed_q   <= armed_d;
            gap_q     <= gap_d;
            start     <= (state_d == LAUNCH);
            busy      <= (state_d != IDLE);
            rsp_valid <= (state_d == RESP);
            if (pop) begin
                vector_id <= head.vector_id;
                epsilon   <= head.epsilon;
            end
            if (cap_done) begin
                rsp_vector_id     <= vector_id;
                rsp_seal          <= seal;
                rsp_true_delivery <= true_delivery;
                rsp_timeout       <= 1'b0;
            end else if (cap_timeout) begin
                rsp_vector_id     <= vector_id;
                rsp_seal          <= SEALW'(0);
                rsp_true_delivery <= 1'b0;
                rsp_timeout       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iso16_vector_sequencer.sv
// Scoreboard bench for iso16_vector_sequencer: a delivery-loop model reacts to start pulses,
// predicts each response from the seal_ready waveform it drives, and a monitor checks the DUT.
`timescale 1ns/1ps
module tb_iso16_vector_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [15:0]   cmd_vector_id;
    logic [31:0]   cmd_epsilon;
    logic          start;
    logic [15:0]   vector_id;
    logic [31:0]   epsilon;
    logic          seal_ready;
    logic          true_delivery;
    logic [255:0]  seal;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_vector_id;
    logic [255:0]  rsp_seal;
    logic          rsp_true_delivery;
    logic          rsp_timeout;
    logic          busy;
    logic [CW-1:0] cmd_count;

    iso16_vector_sequencer #(
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_vector_id     (cmd_vector_id),
        .cmd_epsilon       (cmd_epsilon),
        .start             (start),
        .vector_id         (vector_id),
        .epsilon           (epsilon),
        .seal_ready        (seal_ready),
        .true_delivery     (true_delivery),
        .seal              (seal),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_vector_id     (rsp_vector_id),
        .rsp_seal          (rsp_seal),
        .rsp_true_delivery (rsp_true_delivery),
        .rsp_timeout       (rsp_timeout),
        .busy              (busy),
        .cmd_count         (cmd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] id;
        logic [31:0] eps;
        int          cyc;
    } cmd_rec_t;

    typedef struct {
        int lo;
        int hi;
    } plan_t;

    typedef struct {
        int           cyc;
        logic [255:0] seal;
        logic         td;
        logic         tmo;
    } exp_t;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_starts = 0;
    int          n_rsps = 0;
    int          last_acc = -1000;
    bit          in_rsp = 0;
    bit          rst_pend = 0;
    int          rdy_mode = 1;
    cmd_rec_t    cmd_model[$];
    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [15:0] id_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // seal_ready seen by the DUT rel cycles after start: stale-high, then low, then raised
    function automatic logic sr_f(input plan_t p, input int rel);
        return (rel < p.lo) ? 1'b1 : ((rel < p.hi) ? 1'b0 : 1'b1);
    endfunction

    function automatic logic [255:0] seal_f(input logic [15:0] tag, input int rel);
        logic [31:0] w;
        w = {tag, 16'(rel)};
        return {8{w}};
    endfunction

    // Delivery-loop model: drives seal_ready/seal/verdict and predicts the response per run
    initial begin : delivery
        plan_t        p;
        logic [15:0]  tag;
        logic         tdb;
        int           run_s;
        int           post_rst;
        bit           run_act;
        bit           seen_low;
        int           k_done;
        int           rel;
        exp_t         e;
        seal_ready    = 1'b0;
        true_delivery = 1'b0;
        seal          = '0;
        run_act       = 0;
        post_rst      = 0;
        run_s         = 0;
        tag           = '0;
        tdb           = 1'b0;
        p.lo          = 1;
        p.hi          = 2;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                run_act  = 0;
                post_rst = 0;
            end else if (start) begin
                run_s   = cyc;
                run_act = 1;
                if (plan_q.size() != 0) begin
                    p = plan_q.pop_front();
                end else begin
                    p.lo = $urandom_range(1, 5);
                    p.hi = $urandom_range(1, 20);
                end
                tag      = 16'($urandom);
                tdb      = 1'($urandom);
                seen_low = 0;
                k_done   = 0;
                for (int k = 1; k <= TMO; k++) begin
                    if (k_done == 0) begin
                        if (seen_low && sr_f(p, k)) k_done = k;
                        else if (!sr_f(p, k)) seen_low = 1;
                    end
                end
                if (k_done != 0) begin
                    e.cyc  = run_s + k_done + 1;
                    e.seal = seal_f(tag, k_done);
                    e.td   = tdb ^ 1'(k_done);
                    e.tmo  = 1'b0;
                end else begin
                    e.cyc  = run_s + TMO + 1;
                    e.seal = '0;
                    e.td   = 1'b0;
                    e.tmo  = 1'b1;
                end
                exp_q.push_back(e);
            end else if (run_act) begin
                rel           = cyc - run_s;
                seal_ready    = sr_f(p, rel);
                seal          = seal_f(tag, rel);
                true_delivery = tdb ^ 1'(rel);
            end else begin
                post_rst++;
                seal_ready = (post_rst >= 3);
                seal       = {8{32'hDEAD_0000 | 32'(post_rst)}};
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        cmd_rec_t c;
        int       es;
        exp_t     cur;
        logic [15:0] cur_id;
        if (!rst_n) begin
            cmd_model.delete();
            exp_q.delete();
            id_q.delete();
            in_rsp   = 0;
            last_acc = -1000;
            rst_pend = 1;
        end else begin
            if (rst_pend) begin
                chk("rst_start", 256'(start), 256'(0));
                chk("rst_vector_id", 256'(vector_id), 256'(0));
                chk("rst_epsilon", 256'(epsilon), 256'(0));
                chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
                chk("rst_rsp_vector_id", 256'(rsp_vector_id), 256'(0));
                chk("rst_rsp_seal", rsp_seal, 256'(0));
                chk("rst_rsp_true_delivery", 256'(rsp_true_delivery), 256'(0));
                chk("rst_rsp_timeout", 256'(rsp_timeout), 256'(0));
                chk("rst_busy", 256'(busy), 256'(0));
                rst_pend = 0;
            end
            if (start) begin
                n_starts++;
                if (cmd_model.size() == 0) begin
                    fail("spurious_start");
                end else begin
                    c  = cmd_model.pop_front();
                    es = c.cyc + 2;
                    if (last_acc + GAP + 2 > es) es = last_acc + GAP + 2;
                    chk("start_cycle", 256'(cyc), 256'(es));
                    chk("start_vector_id", 256'(vector_id), 256'(c.id));
                    chk("start_epsilon", 256'(epsilon), 256'(c.eps));
                    id_q.push_back(c.id);
                end
            end
            chk("cmd_count", 256'(cmd_count), 256'(cmd_model.size()));
            chk("cmd_ready", 256'(cmd_ready), 256'(cmd_model.size() != DEPTH));
            if (rsp_valid) begin
                if (!in_rsp) begin
                    n_rsps++;
                    if (exp_q.size() == 0 || id_q.size() == 0) begin
                        fail("spurious_rsp");
                    end else begin
                        cur    = exp_q.pop_front();
                        cur_id = id_q.pop_front();
                        in_rsp = 1;
                        chk("rsp_cycle", 256'(cyc), 256'(cur.cyc));
                    end
                end
                if (in_rsp) begin
                    chk("rsp_vector_id", 256'(rsp_vector_id), 256'(cur_id));
                    chk("rsp_seal", rsp_seal, cur.seal);
                    chk("rsp_true_delivery", 256'(rsp_true_delivery), 256'(cur.td));
                    chk("rsp_timeout", 256'(rsp_timeout), 256'(cur.tmo));
                    if (rsp_ready) begin
                        last_acc = cyc;
                        in_rsp   = 0;
                    end
                end
            end else if (in_rsp) begin
                fail("rsp_dropped");
                in_rsp = 0;
            end
            if (cmd_valid && cmd_ready) begin
                c.id  = cmd_vector_id;
                c.eps = cmd_epsilon;
                c.cyc = cyc;
                cmd_model.push_back(c);
            end
        end
    end

    // rsp_ready driver: 0 = held low, 1 = held high, 2 = random
    initial begin : rsp_drv
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_plan(input int lo, input int hi);
        plan_t p;
        p.lo = lo;
        p.hi = hi;
        plan_q.push_back(p);
    endtask

    task automatic offer(input logic [15:0] id, input logic [31:0] eps, input int budget, output bit ok);
        cmd_valid     = 1'b1;
        cmd_vector_id = id;
        cmd_epsilon   = eps;
        ok            = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            done = !busy && cmd_model.size() == 0 && !in_rsp && exp_q.size() == 0;
        end
        if (!done) fail("drain_timeout");
        tick();
    endtask

    initial begin : driver
        bit ok;
        int n_acc;
        int s0;
        int r0;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_vector_id = '0;
        cmd_epsilon   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // single run: seal raised 8 cycles after start
        add_plan(1, 8);
        offer(16'h0001, 32'd10, 5, ok);
        wait_idle(100);

        // stale seal_ready held over from the first run into the second
        add_plan(1, 5);
        add_plan(3, 8);
        offer(16'h0001, 32'd11, 5, ok);
        offer(16'h0002, 32'd12, 5, ok);
        wait_idle(200);

        // timeout, completion on the last WAIT cycle, and one cycle too late
        add_plan(1, 1000);
        add_plan(1, TMO);
        add_plan(1, TMO + 1);
        offer(16'h0003, 32'd13, 5, ok);
        offer(16'h0004, 32'd14, 5, ok);
        offer(16'h0005, 32'd15, 5, ok);
        wait_idle(300);

        // FIFO full under response backpressure
        rdy_mode = 0;
        tick();
        add_plan(1, 4);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            offer(16'h0100 + 16'(i), $urandom, 12, ok);
            if (ok) n_acc++;
        end
        chk("full_accepted", 256'(n_acc), 256'(5));
        @(negedge clk);
        chk("full_cmd_count", 256'(cmd_count), 256'(4));
        chk("full_cmd_ready", 256'(cmd_ready), 256'(0));
        chk("full_rsp_held", 256'(rsp_valid), 256'(1));
        chk("full_busy", 256'(busy), 256'(1));
        tick();
        rdy_mode = 1;
        wait_idle(600);

        // reset in WAIT with two commands still queued
        add_plan(1, 1000);
        offer(16'h0201, 32'd21, 5, ok);
        offer(16'h0202, 32'd22, 5, ok);
        offer(16'h0203, 32'd23, 5, ok);
        repeat (3) tick();
        @(negedge clk);
        chk("pre_rst_cmd_count", 256'(cmd_count), 256'(2));
        chk("pre_rst_busy", 256'(busy), 256'(1));
        tick();
        rst_n = 1'b0;
        plan_q.delete();
        tick();
        rst_n = 1'b1;
        s0 = n_starts;
        r0 = n_rsps;
        repeat (30) tick();
        chk("post_rst_no_start", 256'(n_starts), 256'(s0));
        chk("post_rst_no_rsp", 256'(n_rsps), 256'(r0));
        chk("post_rst_cmd_count", 256'(cmd_count), 256'(0));

        // randomized traffic with random response backpressure
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            offer(16'($urandom), $urandom, 200, ok);
            if (!ok) fail("cmd_accept_timeout");
        end
        rdy_mode = 1;
        wait_idle(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
